// File: rtl/sys_cmd_master_if.sv
`default_nettype none
// ============================================================================
//  Module   : sys_cmd_master_if
//  Brief    : Command / UART byte-stream / response bundle for sys_cmd_master.
//  Revision : 1.0
// ============================================================================
interface sys_cmd_master_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS       = 4,
    parameter int ALU_FUN_WIDTH = 4,
    parameter int ALU_WIDTH     = 16
);
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [1:0]               cmd_type;
    logic [ADDRESS-1:0]       cmd_addr;
    logic [DATA_WIDTH-1:0]    cmd_wdata;
    logic [DATA_WIDTH-1:0]    cmd_op_a;
    logic [DATA_WIDTH-1:0]    cmd_op_b;
    logic [ALU_FUN_WIDTH-1:0] cmd_fun;
    logic [DATA_WIDTH-1:0]    tx_p_data;
    logic                     tx_d_valid;
    logic                     tx_ready;
    logic [DATA_WIDTH-1:0]    rx_p_data;
    logic                     rx_d_valid;
    logic                     rsp_valid;
    logic [ALU_WIDTH-1:0]     rsp_data;
    logic                     rsp_timeout;
    logic                     busy;

    modport master (
        input  cmd_valid, cmd_type, cmd_addr, cmd_wdata, cmd_op_a, cmd_op_b, cmd_fun,
        input  tx_ready, rx_p_data, rx_d_valid,
        output cmd_ready, tx_p_data, tx_d_valid, rsp_valid, rsp_data, rsp_timeout, busy
    );

    modport slave (
        output cmd_valid, cmd_type, cmd_addr, cmd_wdata, cmd_op_a, cmd_op_b, cmd_fun,
        output tx_ready, rx_p_data, rx_d_valid,
        input  cmd_ready, tx_p_data, tx_d_valid, rsp_valid, rsp_data, rsp_timeout, busy
    );
endinterface
`default_nettype wire

// File: rtl/sys_cmd_master.sv
`default_nettype none
// ============================================================================
//  Module   : sys_cmd_master
//  Brief    : Serializes one command into a UART TX frame and reassembles the
//             UART RX response into a single response word (with timeout).
//  Revision : 1.0
// ============================================================================
module sys_cmd_master #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDRESS        = 4,
    parameter int ALU_FUN_WIDTH  = 4,
    parameter int ALU_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  wire logic          clk,
    input  wire logic          rst,
    sys_cmd_master_if.master   bus_io
);

    localparam int TMO_W = 16;
    localparam logic [TMO_W-1:0]      C_TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [DATA_WIDTH-1:0] C_HDR_WR   = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] C_HDR_RD   = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] C_HDR_ALU  = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] C_HDR_NOP  = DATA_WIDTH'(8'hDD);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SEND     = 2'd1,
        S_WAIT_RSP = 2'd2,
        S_DONE     = 2'd3
    } state_e;

    state_e                   state_q,   state_d;
    logic [1:0]               type_q,    type_d;
    logic [ADDRESS-1:0]       addr_q,    addr_d;
    logic [DATA_WIDTH-1:0]    wdata_q,   wdata_d;
    logic [DATA_WIDTH-1:0]    opa_q,     opa_d;
    logic [DATA_WIDTH-1:0]    opb_q,     opb_d;
    logic [ALU_FUN_WIDTH-1:0] fun_q,     fun_d;
    logic [1:0]               idx_q,     idx_d;
    logic                     rxcnt_q,   rxcnt_d;
    logic [DATA_WIDTH-1:0]    lo_q,      lo_d;
    logic [ALU_WIDTH-1:0]     rsp_q,     rsp_d;
    logic                     tmoflag_q, tmoflag_d;
    logic [TMO_W-1:0]         tmo_q,     tmo_d;

    logic [DATA_WIDTH-1:0]    w_frame_byte;
    logic [1:0]               w_last_idx;

    // Frame byte selection by command type and byte index.
    always_comb begin
        w_frame_byte = '0;
        w_last_idx   = 2'd1;
        unique case (type_q)
            2'b00: begin
                w_last_idx = 2'd2;
                case (idx_q)
                    2'd0:    w_frame_byte = C_HDR_WR;
                    2'd1:    w_frame_byte = DATA_WIDTH'(addr_q);
                    default: w_frame_byte = wdata_q;
                endcase
            end
            2'b01: begin
                w_last_idx   = 2'd1;
                w_frame_byte = (idx_q == 2'd0) ? C_HDR_RD : DATA_WIDTH'(addr_q);
            end
            2'b10: begin
                w_last_idx = 2'd3;
                case (idx_q)
                    2'd0:    w_frame_byte = C_HDR_ALU;
                    2'd1:    w_frame_byte = opa_q;
                    2'd2:    w_frame_byte = opb_q;
                    default: w_frame_byte = DATA_WIDTH'(fun_q);
                endcase
            end
            default: begin
                w_last_idx   = 2'd1;
                w_frame_byte = (idx_q == 2'd0) ? C_HDR_NOP : DATA_WIDTH'(fun_q);
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        type_d    = type_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        fun_d     = fun_q;
        idx_d     = idx_q;
        rxcnt_d   = rxcnt_q;
        lo_d      = lo_q;
        rsp_d     = rsp_q;
        tmoflag_d = tmoflag_q;
        tmo_d     = tmo_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus_io.cmd_valid) begin
                    type_d  = bus_io.cmd_type;
                    addr_d  = bus_io.cmd_addr;
                    wdata_d = bus_io.cmd_wdata;
                    opa_d   = bus_io.cmd_op_a;
                    opb_d   = bus_io.cmd_op_b;
                    fun_d   = bus_io.cmd_fun;
                    idx_d   = 2'd0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (bus_io.tx_ready) begin
                    if (idx_q == w_last_idx) begin
                        tmo_d     = '0;
                        rxcnt_d   = 1'b0;
                        tmoflag_d = 1'b0;
                        state_d   = (type_q == 2'b00) ? S_DONE : S_WAIT_RSP;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            S_WAIT_RSP: begin
                // A byte arriving on the expiry cycle takes priority over the timeout.
                if (bus_io.rx_d_valid) begin
                    tmo_d = '0;
                    if (type_q[1] && !rxcnt_q) begin
                        lo_d    = bus_io.rx_p_data;
                        rxcnt_d = 1'b1;
                    end else begin
                        rsp_d   = type_q[1] ? ALU_WIDTH'({bus_io.rx_p_data, lo_q})
                                            : ALU_WIDTH'(bus_io.rx_p_data);
                        state_d = S_DONE;
                    end
                end else if (tmo_q == C_TMO_LAST) begin
                    tmoflag_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            type_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            fun_q     <= '0;
            idx_q     <= '0;
            rxcnt_q   <= 1'b0;
            lo_q      <= '0;
            rsp_q     <= '0;
            tmoflag_q <= 1'b0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            type_q    <= type_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            fun_q     <= fun_d;
            idx_q     <= idx_d;
            rxcnt_q   <= rxcnt_d;
            lo_q      <= lo_d;
            rsp_q     <= rsp_d;
            tmoflag_q <= tmoflag_d;
            tmo_q     <= tmo_d;
        end
    end

    assign bus_io.cmd_ready   = (state_q == S_IDLE);
    assign bus_io.tx_d_valid  = (state_q == S_SEND);
    assign bus_io.tx_p_data   = (state_q == S_SEND) ? w_frame_byte : '0;
    assign bus_io.rsp_valid   = (state_q == S_DONE) && !tmoflag_q;
    assign bus_io.rsp_timeout = (state_q == S_DONE) &&  tmoflag_q;
    assign bus_io.rsp_data    = rsp_q;
    assign bus_io.busy        = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sys_cmd_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sys_cmd_master
//  Brief    : Directed scoreboard bench for sys_cmd_master.
//  Revision : 1.0
// ============================================================================
module tb_sys_cmd_master;

    localparam int C_TMO = 16;

    logic clk;
    logic rst;

    sys_cmd_master_if #(.DATA_WIDTH(8), .ADDRESS(4), .ALU_FUN_WIDTH(4), .ALU_WIDTH(16)) bus ();

    sys_cmd_master #(
        .DATA_WIDTH(8), .ADDRESS(4), .ALU_FUN_WIDTH(4), .ALU_WIDTH(16), .TIMEOUT_CYCLES(C_TMO)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    typedef struct {
        logic [7:0] b;
        int         mode;   // 0 untimed, 1 first byte after accept, 2 right after previous byte
    } tx_exp_t;

    typedef struct {
        logic        is_to;
        logic [15:0] data;
        int          lat;   // cycles after last tx transfer, 0 = not checked
    } rsp_exp_t;

    tx_exp_t  tx_q[$];
    rsp_exp_t rsp_q[$];

    int          checks = 0;
    int          fails  = 0;
    int          cyc    = 0;
    int          accept_cyc  = 0;
    int          last_tx_cyc = 0;
    bit          pend = 0;
    logic [7:0]  pend_b = '0;
    bit          ready_chk = 0;
    bit          toggle_mode = 0;
    logic [15:0] model_rsp = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        bus.tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.tx_ready = toggle_mode ? ((cyc % 4) == 0) : 1'b1;
        end
    end

    // Monitor: compares every DUT presentation against the scoreboard queues.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            pend      = 0;
            ready_chk = 0;
        end else begin
            if (ready_chk) begin
                chk("ready_after_rsp", {31'd0, bus.cmd_ready}, 32'd1);
                ready_chk = 0;
            end
            if (pend) begin
                chk("tx_hold_valid", {31'd0, bus.tx_d_valid}, 32'd1);
                chk("tx_hold_data", {24'd0, bus.tx_p_data}, {24'd0, pend_b});
            end
            if (bus.cmd_valid && bus.cmd_ready) accept_cyc = cyc;
            if (bus.tx_d_valid && bus.tx_ready) begin
                if (tx_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL tx_unexpected actual=%0h required=none", bus.tx_p_data);
                end else begin
                    tx_exp_t e;
                    e = tx_q.pop_front();
                    chk("tx_byte", {24'd0, bus.tx_p_data}, {24'd0, e.b});
                    if (e.mode == 1)      chk("tx_first_lat", cyc, accept_cyc + 1);
                    else if (e.mode == 2) chk("tx_consec", cyc, last_tx_cyc + 1);
                end
                last_tx_cyc = cyc;
            end
            pend   = bus.tx_d_valid && !bus.tx_ready;
            pend_b = bus.tx_p_data;
            if (bus.rsp_valid || bus.rsp_timeout) begin
                chk("rsp_exclusive", {31'd0, bus.rsp_valid && bus.rsp_timeout}, 32'd0);
                if (rsp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL rsp_unexpected actual=v%0b/t%0b/%0h required=none",
                             bus.rsp_valid, bus.rsp_timeout, bus.rsp_data);
                end else begin
                    rsp_exp_t r;
                    r = rsp_q.pop_front();
                    chk("rsp_kind_timeout", {31'd0, bus.rsp_timeout}, {31'd0, r.is_to});
                    chk("rsp_data", {16'd0, bus.rsp_data}, {16'd0, r.data});
                    if (r.lat != 0) chk("rsp_latency", cyc, last_tx_cyc + r.lat);
                end
                ready_chk = 1;
            end
        end
    end

    task automatic push_rsp(input logic is_to, input logic [15:0] d, input int lat);
        rsp_exp_t r;
        r.is_to = is_to;
        r.data  = d;
        r.lat   = lat;
        rsp_q.push_back(r);
    endtask

    task automatic issue(input logic [1:0] t, input logic [3:0] ad, input logic [7:0] wd,
                         input logic [7:0] oa, input logic [7:0] ob, input logic [3:0] f,
                         input bit timed);
        logic [7:0] fr[$];
        int n;
        case (t)
            2'b00:   fr = '{8'hAA, {4'h0, ad}, wd};
            2'b01:   fr = '{8'hBB, {4'h0, ad}};
            2'b10:   fr = '{8'hCC, oa, ob, {4'h0, f}};
            default: fr = '{8'hDD, {4'h0, f}};
        endcase
        for (int i = 0; i < fr.size(); i++) begin
            tx_exp_t e;
            e.b    = fr[i];
            e.mode = !timed ? 0 : (i == 0 ? 1 : 2);
            tx_q.push_back(e);
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_type  = t;
        bus.cmd_addr  = ad;
        bus.cmd_wdata = wd;
        bus.cmd_op_a  = oa;
        bus.cmd_op_b  = ob;
        bus.cmd_fun   = f;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.cmd_ready && n < 200);
        if (!bus.cmd_ready) chk("cmd_accept_wait", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        // Scramble the fields: the DUT must have captured them already.
        bus.cmd_valid = 1'b0;
        bus.cmd_type  = 2'($urandom);
        bus.cmd_addr  = 4'($urandom);
        bus.cmd_wdata = 8'($urandom);
        bus.cmd_op_a  = 8'($urandom);
        bus.cmd_op_b  = 8'($urandom);
        bus.cmd_fun   = 4'($urandom);
    endtask

    task automatic rx(input logic [7:0] b);
        bus.rx_p_data  = b;
        bus.rx_d_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_d_valid = 1'b0;
    endtask

    task automatic wait_tx_empty();
        int n = 0;
        while (tx_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("tx_drain", tx_q.size(), 32'd0);
    endtask

    task automatic wait_done();
        int n = 0;
        while ((rsp_q.size() != 0 || tx_q.size() != 0) && n < 300) begin
            @(posedge clk);
            n++;
        end
        chk("rsp_drain", rsp_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"},   {31'd0, bus.cmd_ready},   32'd1);
        chk({tag, "_tx_d_valid"},  {31'd0, bus.tx_d_valid},  32'd0);
        chk({tag, "_tx_p_data"},   {24'd0, bus.tx_p_data},   32'd0);
        chk({tag, "_rsp_valid"},   {31'd0, bus.rsp_valid},   32'd0);
        chk({tag, "_rsp_data"},    {16'd0, bus.rsp_data},    32'd0);
        chk({tag, "_rsp_timeout"}, {31'd0, bus.rsp_timeout}, 32'd0);
        chk({tag, "_busy"},        {31'd0, bus.busy},        32'd0);
    endtask

    initial begin
        rst            = 1'b1;
        bus.cmd_valid  = 1'b0;
        bus.cmd_type   = '0;
        bus.cmd_addr   = '0;
        bus.cmd_wdata  = '0;
        bus.cmd_op_a   = '0;
        bus.cmd_op_b   = '0;
        bus.cmd_fun    = '0;
        bus.rx_p_data  = '0;
        bus.rx_d_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Write: no rx consumed, rsp_valid the cycle after the last byte.
        push_rsp(1'b0, model_rsp, 1);
        issue(2'b00, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0, 1);
        wait_done();

        // Read with the byte 10 cycles later, then a stray byte that must be dropped.
        model_rsp = 16'h007E;
        push_rsp(1'b0, model_rsp, 0);
        issue(2'b01, 4'h2, 8'h00, 8'h00, 8'h00, 4'h0, 1);
        repeat (10) @(posedge clk);
        #1;
        rx(8'h7E);
        wait_done();
        rx(8'h55);
        repeat (3) @(posedge clk);
        #1;

        // ALU with operands, low byte first.
        model_rsp = 16'h0046;
        push_rsp(1'b0, model_rsp, 0);
        issue(2'b10, 4'h0, 8'h00, 8'h12, 8'h34, 4'h1, 1);
        repeat (6) @(posedge clk);
        #1;
        rx(8'h46);
        rx(8'h00);
        wait_done();

        // ALU without operands under a sparse tx_ready.
        toggle_mode = 1;
        model_rsp = 16'h2211;
        push_rsp(1'b0, model_rsp, 0);
        issue(2'b11, 4'h0, 8'h00, 8'h00, 8'h00, 4'h3, 0);
        wait_tx_empty();
        rx(8'h11);
        rx(8'h22);
        wait_done();
        toggle_mode = 0;
        @(posedge clk);
        #1;

        // Read with no response: timeout 16 cycles after the last tx byte.
        push_rsp(1'b1, model_rsp, C_TMO + 1);
        issue(2'b01, 4'hF, 8'h00, 8'h00, 8'h00, 4'h0, 1);
        wait_done();

        // ALU that receives only the low byte: timeout, response word unchanged.
        push_rsp(1'b1, model_rsp, 0);
        issue(2'b10, 4'h0, 8'h00, 8'h01, 8'h02, 4'hF, 1);
        wait_tx_empty();
        rx(8'h77);
        wait_done();

        // Read whose byte lands on the expiry cycle: the byte wins.
        model_rsp = 16'h0099;
        push_rsp(1'b0, model_rsp, 0);
        issue(2'b01, 4'h3, 8'h00, 8'h00, 8'h00, 4'h0, 1);
        repeat (C_TMO + 1) @(posedge clk);
        #1;
        rx(8'h99);
        wait_done();

        // Reset while the operand A byte is on the TX port.
        issue(2'b10, 4'h0, 8'h00, 8'h12, 8'h34, 4'h1, 1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk_reset_outputs("midreset");
        tx_q.delete();
        rsp_q.delete();
        model_rsp = 16'h0000;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        push_rsp(1'b0, model_rsp, 1);
        issue(2'b00, 4'h9, 8'hA5, 8'h00, 8'h00, 4'h0, 1);
        wait_done();

        repeat (5) @(posedge clk);
        #1;
        chk("final_tx_queue", tx_q.size(), 32'd0);
        chk("final_rsp_queue", rsp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
